matrix_mult_sequencer: RTL and testbench
========================================

# matrix_mult_sequencer

Controller that owns the 2×2 8-bit matrix multiplier core and sequences each operation. It:
- accepts the eight operand bytes as a serial valid/ready stream and holds them stable on the core's operand ports;
- releases the core from reset and waits a fixed pipeline latency;
- captures the four 16-bit results and streams them out with backpressure.

It sits between the host/load path and the multiplier core, and is the only agent that drives the core's reset and operands.

## Interface
- CORE_LATENCY, 6, cycles from core reset release to result capture; legal range 6..15
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort; returns to LOAD
- in_valid  in  1  operand byte valid
- in_ready  out  1  sequencer accepts operand byte
- in_data  in  8  operand byte; order a0,a1,a2,a3,b0,b1,b2,b3
- core_rst  out  1  reset to multiplier core, registered
- core_a0..core_a3  out  8 each  matrix A operands to core
- core_b0..core_b3  out  8 each  matrix B operands to core
- core_r1..core_r4  in  16 each  core results
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- out_data  out  16  result word; order r1,r2,r3,r4
- out_last  out  1  high with r4
- busy  out  1  operation in progress
- op_count  out  16  completed operations, wraps at 2^16

## Operation
- States:
  - LOAD: in_ready=1, core_rst=1.
    - Each handshake (in_valid&in_ready) writes in_data to operand register[idx] and increments idx (0..7).
    - Handshake at idx=7: go to START, idx←0.
  - START: one cycle, in_ready=0, core_rst stays 1; go to WAIT. Deassert core_rst on that transition.
  - WAIT: core_rst=0, cnt increments from 0.
    - At the edge where cnt=CORE_LATENCY-1: latch core_r1..r4 into the result buffer and go to OUT.
  - OUT: out_valid=1, out_data=buffer[oidx].
    - Each handshake increments oidx; out_last=(oidx==3).
    - Handshake at oidx=3: go to LOAD, oidx←0, op_count+1, core_rst←1.
- Operand registers change only on LOAD handshakes. They are stable throughout START/WAIT/OUT.
- Results are passed unmodified, as 16-bit values truncated mod 2^16 by the core: r1=a0b0+a1b2, r2=a0b1+a1b3, r3=a2b0+a3b2, r4=a2b1+a3b3.
- busy = (state≠LOAD) | (idx≠0).
- clear has priority over every handshake:
  - next state LOAD, idx/oidx/cnt←0, core_rst←1, out_valid←0;
  - operand registers and op_count are kept.
- out_valid holds without out_ready. out_data stays stable until accepted.

## Timing
- Reset values:
  - state LOAD, in_ready=1, core_rst=1;
  - all operands 0, result buffer 0, out_valid=0, out_data=0, out_last=0;
  - busy=0, op_count=0, idx/oidx/cnt=0.
- With the final input handshake at edge H:
  - START during the cycle after H;
  - core_rst low from H+1;
  - result latch at H+1+CORE_LATENCY;
  - out_valid high in the following cycle (7 cycles after H at default).
- Minimum throughput with out_ready tied high: 8 load + 1 + CORE_LATENCY + 4 out = 19 cycles per operation.
- in_ready=0 outside LOAD. in_valid is ignored there, with no buffering.
- rst mid-operation clears everything immediately. A partially loaded matrix is discarded.

## Structure
- Package matrix_seq_pkg:
  - state enum {LOAD, START, WAIT, OUT};
  - N_OPERANDS=8, N_RESULTS=4;
  - OPERAND_W=8, RESULT_W=16.
- One sub-module, matrix_operand_loader: the operand register file plus idx counter, with write-enable and clear inputs.
- FSM, latency counter and result serializer live in the top.

## Test plan
- Reset, then load 1,2,3,4,5,6,7,8 back-to-back with out_ready=1 → outputs 19,22,43,50; out_last only on 50; op_count=1; out_valid rises 7 cycles after the 8th handshake.
- Load all 255 → four outputs of 64514 (130050 mod 65536).
- out_ready low for 5 cycles after the first out_valid → out_data holds 19 for the whole stall; the sequence is still 19,22,43,50 with no drops or duplicates.
- clear after 5 of 8 input bytes, then a full new load of 2,0,0,2,3,1,4,5 → outputs 6,2,8,10; the earlier partial bytes have no effect.
- rst asserted mid-WAIT → all outputs at reset values immediately, core_rst=1, op_count=0; the next full load completes normally.
- Toggle in_valid randomly during START/WAIT/OUT → in_ready=0 and operand ports unchanged for the whole operation.

Source files
------------

// File: rtl/matrix_seq_pkg.sv
// Shared types and sizing for the 2x2 matrix multiplier sequencer.
package matrix_seq_pkg;

  localparam int unsigned N_OPERANDS = 8;
  localparam int unsigned N_RESULTS  = 4;
  localparam int unsigned OPERAND_W  = 8;
  localparam int unsigned RESULT_W   = 16;
  localparam int unsigned IDX_W      = $clog2(N_OPERANDS);
  localparam int unsigned OIDX_W     = $clog2(N_RESULTS);
  // Wide enough for the largest legal core latency (15).
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_operand_loader.sv
// Operand register file for the multiplier core, filled serially a0..b3.
module matrix_operand_loader
  import matrix_seq_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 wr_en,
  input  logic [OPERAND_W-1:0]                 wr_data,
  output logic [IDX_W-1:0]                     idx,
  output logic                                 wr_last,
  output logic [N_OPERANDS-1:0][OPERAND_W-1:0] operands
);

  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [N_OPERANDS-1:0][OPERAND_W-1:0] ops_q, ops_d;

  // Next write slot and register contents; clear rewinds the slot but keeps data.
  always_comb begin
    idx_d = idx_q;
    ops_d = ops_q;
    if (clear) begin
      idx_d = '0;
    end else if (wr_en) begin
      ops_d[idx_q] = wr_data;
      if (idx_q == IDX_W'(N_OPERANDS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Register file and write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      ops_q <= '0;
    end else begin
      idx_q <= idx_d;
      ops_q <= ops_d;
    end
  end

  assign idx      = idx_q;
  assign wr_last  = wr_en & (idx_q == IDX_W'(N_OPERANDS - 1));
  assign operands = ops_q;

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Sequences one 2x2 multiply: serial operand load, core run, serial result drain.
module matrix_mult_sequencer
  import matrix_seq_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        core_rst,
  output logic [7:0]  core_a0,
  output logic [7:0]  core_a1,
  output logic [7:0]  core_a2,
  output logic [7:0]  core_a3,
  output logic [7:0]  core_b0,
  output logic [7:0]  core_b1,
  output logic [7:0]  core_b2,
  output logic [7:0]  core_b3,
  input  logic [15:0] core_r1,
  input  logic [15:0] core_r2,
  input  logic [15:0] core_r3,
  input  logic [15:0] core_r4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] op_count
);

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [OIDX_W-1:0]                   oidx_q, oidx_d;
  logic [N_RESULTS-1:0][RESULT_W-1:0]  res_q, res_d;
  logic                                core_rst_q, core_rst_d;
  logic [15:0]                         op_count_q, op_count_d;

  logic                                 load_en;
  logic                                 load_last;
  logic [IDX_W-1:0]                     load_idx;
  logic [N_OPERANDS-1:0][OPERAND_W-1:0] operands;

  assign in_ready = (state_q == LOAD);
  assign load_en  = in_valid & in_ready & ~clear;

  matrix_operand_loader u_loader (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .wr_en    (load_en),
    .wr_data  (in_data),
    .idx      (load_idx),
    .wr_last  (load_last),
    .operands (operands)
  );

  // FSM, latency counter, result capture and output serializer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    oidx_d     = oidx_q;
    res_d      = res_q;
    op_count_d = op_count_q;
    unique case (state_q)
      LOAD: begin
        if (load_last) state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(CORE_LATENCY - 1)) begin
          res_d   = {core_r4, core_r3, core_r2, core_r1};
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          if (oidx_q == OIDX_W'(N_RESULTS - 1)) begin
            oidx_d     = '0;
            op_count_d = op_count_q + 16'd1;
            state_d    = LOAD;
          end else begin
            oidx_d = oidx_q + OIDX_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (clear) begin
      state_d = LOAD;
      cnt_d   = '0;
      oidx_d  = '0;
    end
    // Core reset is a registered image of the next state: released only while running/draining.
    core_rst_d = (state_d == LOAD) || (state_d == START);
  end

  // Control and result state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      oidx_q     <= '0;
      res_q      <= '0;
      core_rst_q <= 1'b1;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oidx_q     <= oidx_d;
      res_q      <= res_d;
      core_rst_q <= core_rst_d;
      op_count_q <= op_count_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign core_a0   = operands[0];
  assign core_a1   = operands[1];
  assign core_a2   = operands[2];
  assign core_a3   = operands[3];
  assign core_b0   = operands[4];
  assign core_b1   = operands[5];
  assign core_b2   = operands[6];
  assign core_b3   = operands[7];
  assign out_valid = (state_q == OUT);
  assign out_data  = res_q[oidx_q];
  assign out_last  = (state_q == OUT) && (oidx_q == OIDX_W'(N_RESULTS - 1));
  assign busy      = (state_q != LOAD) || (load_idx != '0);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Bench for matrix_mult_sequencer with a latency-exact behavioural multiplier core.
module tb_matrix_mult_sequencer;

  localparam int unsigned LAT = 6;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, core_rst, out_valid, out_last, busy;
  logic [7:0]  core_a0, core_a1, core_a2, core_a3;
  logic [7:0]  core_b0, core_b1, core_b2, core_b3;
  logic [15:0] core_r1, core_r2, core_r3, core_r4;
  logic [15:0] out_data, op_count;

  int total = 0;
  int bad   = 0;
  int exp_ops = 0;
  int unsigned core_age = 0;
  logic [7:0]  ops [8];
  logic [15:0] exp_r [4];

  matrix_mult_sequencer #(.CORE_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_rst(core_rst),
    .core_a0(core_a0), .core_a1(core_a1), .core_a2(core_a2), .core_a3(core_a3),
    .core_b0(core_b0), .core_b1(core_b1), .core_b2(core_b2), .core_b3(core_b3),
    .core_r1(core_r1), .core_r2(core_r2), .core_r3(core_r3), .core_r4(core_r4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Core stand-in: results are only valid once it has run LAT-1 edges out of reset.
  always @(posedge clk) begin
    if (core_rst) core_age <= 0;
    else if (core_age < 1000) core_age <= core_age + 1;
  end

  always_comb begin
    if (core_age >= LAT - 1) begin
      core_r1 = 16'(int'(core_a0) * int'(core_b0) + int'(core_a1) * int'(core_b2));
      core_r2 = 16'(int'(core_a0) * int'(core_b1) + int'(core_a1) * int'(core_b3));
      core_r3 = 16'(int'(core_a2) * int'(core_b0) + int'(core_a3) * int'(core_b2));
      core_r4 = 16'(int'(core_a2) * int'(core_b1) + int'(core_a3) * int'(core_b3));
    end else begin
      core_r1 = 16'hDEA1;
      core_r2 = 16'hDEA2;
      core_r3 = 16'hDEA3;
      core_r4 = 16'hDEA4;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C = A x B over row-major 2x2 matrices, reduced mod 2^16.
  task automatic compute_ref();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int s = 0;
        for (int k = 0; k < 2; k++) s += int'(ops[i*2+k]) * int'(ops[4+k*2+j]);
        exp_r[i*2+j] = 16'(s % 65536);
      end
    end
  endtask

  function automatic logic [63:0] port_ops();
    return {core_a0, core_a1, core_a2, core_a3, core_b0, core_b1, core_b2, core_b3};
  endfunction

  function automatic logic [63:0] want_ops();
    return {ops[0], ops[1], ops[2], ops[3], ops[4], ops[5], ops[6], ops[7]};
  endfunction

  // Presents ops[0..count-1]; called and returns at a negedge.
  task automatic load_bytes(input int count, input bit gaps);
    for (int n = 0; n < count; n++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = ops[n];
      check("in_ready_load", in_ready, 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Full operation: load, watch the core run, drain results.
  task automatic run_op(input int stall, input bit gaps, input bit rnd_ready);
    int waited = 0;
    int k = 0;
    int guard = 0;
    int stall_left = stall;
    compute_ref();
    out_ready = 1'b1;
    load_bytes(8, gaps);
    while (!out_valid && waited < 50) begin
      check("in_ready_busy", in_ready, 1'b0);
      check("busy_run", busy, 1'b1);
      check("core_rst_run", core_rst, (waited == 0));
      check("operands_stable", port_ops(), want_ops());
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
      waited++;
    end
    check("result_latency", waited, LAT + 1);
    while (k < 4 && guard < 100) begin
      check("out_valid", out_valid, 1'b1);
      check("out_data", out_data, exp_r[k]);
      check("out_last", out_last, (k == 3));
      check("in_ready_out", in_ready, 1'b0);
      check("operands_out", port_ops(), want_ops());
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rnd_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (out_ready) k++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    exp_ops++;
    check("out_valid_done", out_valid, 1'b0);
    check("op_count", op_count, 16'(exp_ops));
    check("busy_done", busy, 1'b0);
    check("core_rst_done", core_rst, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'd0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_op_count", op_count, 16'd0);
    check("rst_operands", port_ops(), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed 1..8 with no backpressure.
    for (int i = 0; i < 8; i++) ops[i] = 8'(i + 1);
    run_op(0, 1'b0, 1'b0);

    // Saturated operands wrap mod 2^16.
    for (int i = 0; i < 8; i++) ops[i] = 8'hFF;
    run_op(0, 1'b0, 1'b0);

    // Five-cycle stall on the first result word.
    for (int i = 0; i < 8; i++) ops[i] = 8'(i + 1);
    run_op(5, 1'b0, 1'b0);

    // Partial load aborted by clear (with a coincident valid byte), then a fresh load.
    for (int i = 0; i < 8; i++) ops[i] = 8'($urandom);
    load_bytes(5, 1'b0);
    check("busy_partial", busy, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check("busy_after_clear", busy, 1'b0);
    check("op_count_after_clear", op_count, 16'(exp_ops));
    ops = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd3, 8'd1, 8'd4, 8'd5};
    run_op(0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the core wait.
    for (int i = 0; i < 8; i++) ops[i] = 8'($urandom);
    load_bytes(8, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_core_rst", core_rst, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 16'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_op_count", op_count, 16'd0);
    check("midrst_operands", port_ops(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) ops[i] = 8'($urandom);
    run_op(0, 1'b0, 1'b0);

    // Random operands, input gaps and random output backpressure.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) ops[i] = 8'($urandom);
      run_op(int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
